// File: rtl/zoom_frame_serializer.sv
// Streams one packed NLARGURA x NALTURA frame out pixel by pixel in raster order, with a
// one-frame shadow buffer. Optional per-frame checksum ports enabled by ZOOM_CHECKSUM_EN.
module zoom_frame_serializer #(
    parameter int unsigned NLARGURA = 2,
    parameter int unsigned NALTURA  = 2,
    parameter int unsigned PIXEL_W  = 8
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic [NLARGURA*NALTURA*PIXEL_W-1:0]    frame_in,
    input  logic                                   frame_valid,
    output logic                                   frame_ready,
    output logic [PIXEL_W-1:0]                     pix_data,
    output logic                                   pix_valid,
    input  logic                                   pix_ready,
    output logic                                   pix_sof,
    output logic                                   pix_eol,
    output logic                                   pix_eof,
    output logic                                   busy
`ifdef ZOOM_CHECKSUM_EN
    ,
    output logic [15:0]                            frame_sum,
    output logic                                   frame_sum_valid
`endif
);

    localparam int unsigned NPIX    = NLARGURA * NALTURA;
    localparam int unsigned FRAME_W = NPIX * PIXEL_W;
    localparam int unsigned MAXD    = (NLARGURA > NALTURA) ? NLARGURA : NALTURA;
    localparam int unsigned CW      = $clog2(MAXD + 1);

    typedef enum logic {StIdle, StStream} state_t;

    state_t               state_q, state_d;
    logic [FRAME_W-1:0]   active_q, active_d;
    logic [FRAME_W-1:0]   shadow_q, shadow_d;
    logic                 shadow_full_q, shadow_full_d;
    logic [CW-1:0]        linha_q, linha_d;
    logic [CW-1:0]        coluna_q, coluna_d;
    logic                 ready_en_q;
    logic                 accept, pix_hs, col_last, row_last, frame_last;
    logic [PIXEL_W-1:0]   pix_cur;
    int unsigned          pix_idx;

    assign col_last   = (coluna_q == CW'(NLARGURA - 1));
    assign row_last   = (linha_q == CW'(NALTURA - 1));
    assign frame_last = col_last & row_last;

    // ready_en_q keeps frame_ready low during reset and until the first edge after release
    assign frame_ready = ready_en_q & ((state_q == StIdle) | ~shadow_full_q);
    assign accept      = frame_valid & frame_ready;
    assign pix_valid   = (state_q == StStream);
    assign busy        = pix_valid;
    assign pix_hs      = pix_valid & pix_ready;

    always_comb begin
        pix_idx = NLARGURA * 32'(linha_q) + 32'(coluna_q);
        pix_cur = '0;
        for (int unsigned k = 0; k < NPIX; k++) begin
            if (k == pix_idx) begin
                pix_cur = active_q[(NPIX-1-k)*PIXEL_W +: PIXEL_W];
            end
        end
    end

    assign pix_data = pix_valid ? pix_cur : '0;
    assign pix_sof  = pix_valid & (linha_q == '0) & (coluna_q == '0);
    assign pix_eol  = pix_valid & col_last;
    assign pix_eof  = pix_valid & frame_last;

    always_comb begin
        state_d       = state_q;
        active_d      = active_q;
        shadow_d      = shadow_q;
        shadow_full_d = shadow_full_q;
        linha_d       = linha_q;
        coluna_d      = coluna_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    active_d = frame_in;
                    linha_d  = '0;
                    coluna_d = '0;
                    state_d  = StStream;
                end
            end
            StStream: begin
                if (pix_hs && frame_last) begin
                    linha_d  = '0;
                    coluna_d = '0;
                    // Next frame takes over on the same edge so the stream has no bubble
                    if (shadow_full_q) begin
                        active_d      = shadow_q;
                        shadow_full_d = 1'b0;
                    end else if (accept) begin
                        active_d = frame_in;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    if (pix_hs) begin
                        if (col_last) begin
                            coluna_d = '0;
                            linha_d  = linha_q + 1'b1;
                        end else begin
                            coluna_d = coluna_q + 1'b1;
                        end
                    end
                    if (accept) begin
                        shadow_d      = frame_in;
                        shadow_full_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            active_q      <= '0;
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
            linha_q       <= '0;
            coluna_q      <= '0;
            ready_en_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            active_q      <= active_d;
            shadow_q      <= shadow_d;
            shadow_full_q <= shadow_full_d;
            linha_q       <= linha_d;
            coluna_q      <= coluna_d;
            ready_en_q    <= 1'b1;
        end
    end

`ifdef ZOOM_CHECKSUM_EN
    logic [15:0] sum_q;
    logic [15:0] sum_next;

    assign sum_next = sum_q + 16'(pix_cur);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sum_q           <= '0;
            frame_sum       <= '0;
            frame_sum_valid <= 1'b0;
        end else begin
            frame_sum_valid <= 1'b0;
            if (pix_hs) begin
                if (frame_last) begin
                    frame_sum       <= sum_next;
                    frame_sum_valid <= 1'b1;
                    sum_q           <= '0;
                end else begin
                    sum_q <= sum_next;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_zoom_frame_serializer.sv
// Self-checking bench for zoom_frame_serializer: a queue of expected pixels plus a count of
// frames in flight predicts every output each cycle; directed tests pin literal sequences.
module tb_zoom_frame_serializer;

    localparam int NL   = 2;
    localparam int NA   = 2;
    localparam int PW   = 8;
    localparam int NPIX = NL * NA;
    localparam int FW   = NPIX * PW;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [FW-1:0] frame_in = '0;
    logic          frame_valid = 1'b0;
    logic          pix_ready = 1'b0;
    logic          frame_ready, pix_valid, pix_sof, pix_eol, pix_eof, busy;
    logic [PW-1:0] pix_data;
`ifdef ZOOM_CHECKSUM_EN
    logic [15:0]   frame_sum;
    logic          frame_sum_valid;
`endif

    zoom_frame_serializer #(.NLARGURA(NL), .NALTURA(NA), .PIXEL_W(PW)) dut (
        .clock       (clock),
        .reset       (reset),
        .frame_in    (frame_in),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_sof     (pix_sof),
        .pix_eol     (pix_eol),
        .pix_eof     (pix_eof),
        .busy        (busy)
`ifdef ZOOM_CHECKSUM_EN
        ,
        .frame_sum       (frame_sum),
        .frame_sum_valid (frame_sum_valid)
`endif
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [PW-1:0] d;
        logic          sof;
        logic          eol;
        logic          eof;
    } pix_t;

    pix_t exp_q[$];
    pix_t seen_q[$];
    int   checks = 0;
    int   failures = 0;
    bit   rdy_en = 1'b0;
    bit   pend = 1'b0;
    logic [15:0] pend_sum = '0;
    logic [15:0] sum_acc = '0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endfunction

    // Expands a frame into its raster-order pixels with their markers
    function automatic void push_frame(logic [FW-1:0] f);
        for (int k = 0; k < NPIX; k++) begin
            pix_t p;
            p.d   = PW'(f >> ((NPIX - 1 - k) * PW));
            p.sof = (k == 0);
            p.eol = ((k % NL) == NL - 1);
            p.eof = (k == NPIX - 1);
            exp_q.push_back(p);
        end
    endfunction

    function automatic void check_pix(string name, int idx, logic [PW-1:0] d, bit sof, bit eol,
                                      bit eof);
        pix_t s;
        s = (idx < seen_q.size()) ? seen_q[idx] : '0;
        check({name, "_data"}, 32'(s.d), 32'(d));
        check({name, "_flags"}, 32'({s.sof, s.eol, s.eof}), 32'({sof, eol, eof}));
    endfunction

    // Compare process: checks outputs against the model, then advances the model to the next edge
    always @(negedge clock) begin
        int   inflight;
        bit   exp_ready;
        pix_t p, s;
        if (reset) begin
            exp_q.delete();
            rdy_en  = 1'b0;
            pend    = 1'b0;
            sum_acc = '0;
            check("rst_frame_ready", 32'(frame_ready), 32'(0));
            check("rst_pix_valid", 32'(pix_valid), 32'(0));
            check("rst_busy", 32'(busy), 32'(0));
            check("rst_pix_data", 32'(pix_data), 32'(0));
            check("rst_markers", 32'({pix_sof, pix_eol, pix_eof}), 32'(0));
`ifdef ZOOM_CHECKSUM_EN
            check("rst_sum", 32'({frame_sum_valid, frame_sum}), 32'(0));
`endif
        end else begin
            inflight  = (exp_q.size() + NPIX - 1) / NPIX;
            exp_ready = rdy_en && (inflight < 2);
            check("frame_ready", 32'(frame_ready), 32'(exp_ready));
            check("pix_valid", 32'(pix_valid), 32'(inflight > 0));
            check("busy", 32'(busy), 32'(inflight > 0));
            if (exp_q.size() > 0) begin
                check("pix_data", 32'(pix_data), 32'(exp_q[0].d));
                check("markers", 32'({pix_sof, pix_eol, pix_eof}),
                      32'({exp_q[0].sof, exp_q[0].eol, exp_q[0].eof}));
            end
`ifdef ZOOM_CHECKSUM_EN
            check("sum_valid", 32'(frame_sum_valid), 32'(pend));
            if (pend) check("frame_sum", 32'(frame_sum), 32'(pend_sum));
`endif
            pend = 1'b0;
            if (exp_q.size() > 0 && pix_ready) begin
                p = exp_q.pop_front();
                s.d = pix_data; s.sof = pix_sof; s.eol = pix_eol; s.eof = pix_eof;
                seen_q.push_back(s);
                if (p.eof) begin
                    pend     = 1'b1;
                    pend_sum = sum_acc + 16'(p.d);
                    sum_acc  = '0;
                end else begin
                    sum_acc = sum_acc + 16'(p.d);
                end
            end
            if (frame_valid && exp_ready) push_frame(frame_in);
            rdy_en = 1'b1;
        end
    end

    task automatic send(logic [FW-1:0] f);
        bit ok = 1'b0;
        frame_in    = f;
        frame_valid = 1'b1;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clock);
            if (frame_ready) ok = 1'b1;
        end
        if (!ok) check("accept_timeout", 32'(0), 32'(1));
        @(posedge clock);
        #1 frame_valid = 1'b0;
    endtask

    task automatic cycles(int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        // Test 1: reset
        cycles(3);
        check("t1_ready_in_reset", 32'(frame_ready), 32'(0));
        reset = 1'b0;
        @(negedge clock);
        check("t1_ready_before_edge", 32'(frame_ready), 32'(0));
        cycles(1);
        check("t1_ready_after_edge", 32'(frame_ready), 32'(1));

        // Test 2: single frame
        pix_ready = 1'b1;
        seen_q.delete();
        send(32'h01_03_09_0B);
        cycles(6);
        check("t2_count", 32'(seen_q.size()), 32'(4));
        check_pix("t2_p0", 0, 8'h01, 1, 0, 0);
        check_pix("t2_p1", 1, 8'h03, 0, 1, 0);
        check_pix("t2_p2", 2, 8'h09, 0, 0, 0);
        check_pix("t2_p3", 3, 8'h0B, 0, 1, 1);
        check("t2_valid_low", 32'(pix_valid), 32'(0));
`ifdef ZOOM_CHECKSUM_EN
        check("t2_sum", 32'(frame_sum), 32'(16'h0018));
`endif

        // Test 3: back-pressure 1,0,0,1,...
        seen_q.delete();
        send(32'h01_03_09_0B);
        for (int i = 0; i < 16; i++) begin
            pix_ready = pat[i % 4];
            cycles(1);
        end
        pix_ready = 1'b1;
        cycles(4);
        check("t3_count", 32'(seen_q.size()), 32'(4));
        check_pix("t3_p0", 0, 8'h01, 1, 0, 0);
        check_pix("t3_p1", 1, 8'h03, 0, 1, 0);
        check_pix("t3_p2", 2, 8'h09, 0, 0, 0);
        check_pix("t3_p3", 3, 8'h0B, 0, 1, 1);

        // Test 4: back-to-back frames
        seen_q.delete();
        send(32'h01_03_09_0B);
        send(32'hAA_BB_CC_DD);
        @(negedge clock);
        check("t4_ready_shadow_full", 32'(frame_ready), 32'(0));
        cycles(10);
        check("t4_count", 32'(seen_q.size()), 32'(8));
        check_pix("t4_p3", 3, 8'h0B, 0, 1, 1);
        check_pix("t4_p4", 4, 8'hAA, 1, 0, 0);
        check_pix("t4_p7", 7, 8'hDD, 0, 1, 1);

        // Test 5: reset after two pixels
        seen_q.delete();
        send(32'h11_22_33_44);
        for (int i = 0; i < 20 && seen_q.size() < 2; i++) @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        check("t5_valid_reset", 32'(pix_valid), 32'(0));
        check("t5_ready_reset", 32'(frame_ready), 32'(0));
        cycles(1);
        reset = 1'b0;
        cycles(1);
        seen_q.delete();
        send(32'h55_66_77_88);
        cycles(6);
        check("t5_count", 32'(seen_q.size()), 32'(4));
        check_pix("t5_p0", 0, 8'h55, 1, 0, 0);

        // Test 6: shadow-full stall
        seen_q.delete();
        pix_ready = 1'b0;
        send(32'h01_03_09_0B);
        send(32'hAA_BB_CC_DD);
        frame_in    = 32'hC1_C2_C3_C4;
        frame_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("t6_ready_stall", 32'(frame_ready), 32'(0));
        end
        @(posedge clock);
        #1 pix_ready = 1'b1;
        send(32'hC1_C2_C3_C4);
        cycles(14);
        check("t6_count", 32'(seen_q.size()), 32'(12));
        check_pix("t6_p4", 4, 8'hAA, 1, 0, 0);
        check_pix("t6_p8", 8, 8'hC1, 1, 0, 0);
        check_pix("t6_p11", 11, 8'hC4, 0, 1, 1);

        // Random phase
        for (int i = 0; i < 3000; i++) begin
            pix_ready   = ($urandom_range(0, 3) != 0);
            frame_valid = ($urandom_range(0, 2) == 0);
            frame_in    = FW'($urandom);
            reset       = ($urandom_range(0, 499) == 0);
            cycles(1);
        end
        reset       = 1'b0;
        frame_valid = 1'b0;
        pix_ready   = 1'b1;
        cycles(20);
        check("drain_idle", 32'(pix_valid), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
